mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory with fixed LAT-cycle access.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default build always favours data on a tie.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_sel_d;
  logic        r_i_ack;
  logic        r_d_ack;
  logic [15:0] r_i_rdata;
  logic [15:0] r_d_rdata;
  logic        r_mem_en;
  logic        r_mem_wr;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_din;
  logic        r_busy;
  logic        w_any_req;
  logic        w_grant_d;
  logic        w_grant_wr;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted most recently; reset value (0) makes the first tie go to data.
  logic r_last_d;
  assign w_grant_d = d_req & (~i_req | ~r_last_d);
`else
  assign w_grant_d = d_req;
`endif

  assign w_any_req  = i_req | d_req;
  assign w_grant_wr = w_grant_d & d_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_sel_d    <= 1'b0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_rdata  <= 16'd0;
      r_d_rdata  <= 16'd0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= 16'd0;
      r_mem_din  <= 16'd0;
      r_busy     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          if (w_any_req) begin
            r_sel_d    <= w_grant_d;
            r_mem_en   <= 1'b1;
            r_mem_wr   <= w_grant_wr;
            r_mem_addr <= w_grant_d ? d_addr : i_addr;
            r_mem_din  <= w_grant_wr ? d_wdata : 16'd0;
            r_cnt      <= 4'(LAT - 1);
            r_busy     <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d   <= w_grant_d;
`endif
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            // Last enabled cycle: memory data is valid now; drop the bus back to zero.
            if (r_sel_d) begin
              if (!r_mem_wr) r_d_rdata <= mem_data_out;
              r_d_ack <= 1'b1;
            end else begin
              r_i_rdata <= mem_data_out;
              r_i_ack   <= 1'b1;
            end
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= 16'd0;
            r_mem_din  <= 16'd0;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ack       = r_i_ack;
  assign d_ack       = r_d_ack;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign mem_enable  = r_mem_en;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_din;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=4 instance for most scenarios, LAT=1 instance for the fast-loop case.
// Handshake: a requester holds req and its payload until it sees its ack, then drops req before the next IDLE.
module tb_mem_arbiter;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // LAT=4 instance
  logic        i_req = 0, d_req = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rd = 0;
  logic        i_ack, d_ack, mem_enable, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
  logic [1:0]  dbg_state;
  int          en_cnt = 0;

  // LAT=1 instance
  logic        l1_i_req = 0, l1_d_req = 0, l1_d_wr = 0;
  logic [15:0] l1_i_addr = 0, l1_d_addr = 0, l1_d_wdata = 0, l1_mem_rd = 0;
  logic        l1_i_ack, l1_d_ack, l1_mem_enable, l1_mem_wr, l1_busy;
  logic [15:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_data_in, l1_mem_data_out;
  logic [1:0]  l1_dbg_state;
  int          l1_en_cnt = 0;

  // Memory model: read data = mem_rd ^ address, valid only in the LAT-th enabled cycle.
  always @(posedge clk) en_cnt <= mem_enable ? en_cnt + 1 : 0;
  always @(posedge clk) l1_en_cnt <= l1_mem_enable ? l1_en_cnt + 1 : 0;
  assign mem_data_out    = (mem_enable && en_cnt == LAT0 - 1) ? (mem_rd ^ mem_addr) : 16'hDEAD;
  assign l1_mem_data_out = (l1_mem_enable && l1_en_cnt == LAT1 - 1) ? (l1_mem_rd ^ l1_mem_addr) : 16'hDEAD;

  mem_arbiter #(.LAT(LAT0)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  mem_arbiter #(.LAT(LAT1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_wr(l1_d_wr), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_enable(l1_mem_enable), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
    .mem_data_in(l1_mem_data_in), .mem_data_out(l1_mem_data_out),
    .busy(l1_busy), .o_dbg_state(l1_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_req = 0; d_req = 0; l1_i_req = 0; l1_d_req = 0;
    apply_reset();
    checks++;
    if ({i_ack, i_rdata, d_ack, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in, busy, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_lat4: got ack=%b/%b en=%b busy=%b st=%0d rd=%h/%h, want all 0",
               i_ack, d_ack, mem_enable, busy, dbg_state, i_rdata, d_rdata);
    end
    checks++;
    if ({l1_i_ack, l1_i_rdata, l1_d_ack, l1_d_rdata, l1_mem_enable, l1_mem_wr, l1_mem_addr,
         l1_mem_data_in, l1_busy, l1_dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_lat1: got ack=%b/%b en=%b busy=%b, want all 0",
               l1_i_ack, l1_d_ack, l1_mem_enable, l1_busy);
    end
  endtask

  task automatic test_fetch();
    logic [4:0] exp_ctl;
    apply_reset();
    mem_rd = 16'hA5A5 ^ 16'h0010;
    i_addr = 16'h0010;
    i_req  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      // {mem_enable, i_ack, d_ack, busy, mem_wr}
      exp_ctl = {1'(k <= 4), 1'(k == 5), 1'b0, 1'(k <= 5), 1'b0};
      checks++;
      if ({mem_enable, i_ack, d_ack, busy, mem_wr} !== exp_ctl) begin
        failures++;
        $display("FAIL fetch_ctl cycle %0d: got %b want %b", k, {mem_enable, i_ack, d_ack, busy, mem_wr}, exp_ctl);
      end
      checks++;
      if (dbg_state !== ((k <= 4) ? 2'd1 : (k == 5) ? 2'd2 : 2'd0)) begin
        failures++;
        $display("FAIL fetch_state cycle %0d: got %0d", k, dbg_state);
      end
      if (k <= 4) begin
        checks++;
        if (mem_addr !== 16'h0010 || mem_data_in !== 16'h0000) begin
          failures++;
          $display("FAIL fetch_bus cycle %0d: got addr=%h din=%h want 0010/0000", k, mem_addr, mem_data_in);
        end
      end
      if (k == 5) begin
        checks++;
        if (i_rdata !== 16'hA5A5) begin
          failures++;
          $display("FAIL fetch_rdata: got %h want a5a5", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_load();
    logic [4:0] exp_ctl;
    mem_rd = 16'hBEEF ^ 16'h0300;
    d_addr = 16'h0300;
    d_wr   = 1'b0;
    d_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      // {mem_enable, mem_wr, d_ack, i_ack, busy}
      exp_ctl = {1'(k <= 4), 1'b0, 1'(k == 5), 1'b0, 1'(k <= 5)};
      checks++;
      if ({mem_enable, mem_wr, d_ack, i_ack, busy} !== exp_ctl) begin
        failures++;
        $display("FAIL load_ctl cycle %0d: got %b want %b", k, {mem_enable, mem_wr, d_ack, i_ack, busy}, exp_ctl);
      end
      if (k <= 4) begin
        checks++;
        if (mem_addr !== 16'h0300) begin
          failures++;
          $display("FAIL load_addr cycle %0d: got %h want 0300", k, mem_addr);
        end
      end
      if (k == 5) begin
        checks++;
        if (d_rdata !== 16'hBEEF || i_rdata !== 16'hA5A5) begin
          failures++;
          $display("FAIL load_rdata: got d=%h i=%h want beef/a5a5", d_rdata, i_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    logic [3:0] exp_ctl;
    mem_rd  = 16'hFFFF;
    d_addr  = 16'h0200;
    d_wdata = 16'h1234;
    d_wr    = 1'b1;
    d_req   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      // {mem_enable, mem_wr, d_ack, i_ack}
      exp_ctl = {1'(k <= 4), 1'(k <= 4), 1'(k == 5), 1'b0};
      checks++;
      if ({mem_enable, mem_wr, d_ack, i_ack} !== exp_ctl) begin
        failures++;
        $display("FAIL store_ctl cycle %0d: got %b want %b", k, {mem_enable, mem_wr, d_ack, i_ack}, exp_ctl);
      end
      checks++;
      if (mem_data_in !== ((k <= 4) ? 16'h1234 : 16'h0000) || (k <= 4 && mem_addr !== 16'h0200)) begin
        failures++;
        $display("FAIL store_bus cycle %0d: got din=%h addr=%h", k, mem_data_in, mem_addr);
      end
      if (k == 5) begin
        checks++;
        if (d_rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL store_keeps_rdata: got %h want beef", d_rdata);
        end
        d_req = 1'b0;
        d_wr  = 1'b0;
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_ctl;
    apply_reset();
    mem_rd = 16'h0000;
    i_addr = 16'h0040;
    d_addr = 16'h0080;
    d_wr   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      // {mem_enable, d_ack, i_ack, busy}
      exp_ctl = {1'((k >= 1 && k <= 4) || (k >= 7 && k <= 10)), 1'(k == 5), 1'(k == 11),
                 1'(k <= 5 || (k >= 7 && k <= 11))};
      checks++;
      if ({mem_enable, d_ack, i_ack, busy} !== exp_ctl) begin
        failures++;
        $display("FAIL priority_ctl cycle %0d: got %b want %b", k, {mem_enable, d_ack, i_ack, busy}, exp_ctl);
      end
      if (mem_enable) begin
        checks++;
        if (mem_addr !== ((k <= 4) ? 16'h0080 : 16'h0040)) begin
          failures++;
          $display("FAIL priority_addr cycle %0d: got %h", k, mem_addr);
        end
      end
      if (k == 5) begin
        checks++;
        if (d_rdata !== 16'h0080) begin
          failures++;
          $display("FAIL priority_drdata: got %h want 0080", d_rdata);
        end
        d_req = 1'b0;
      end
      if (k == 11) begin
        checks++;
        if (i_rdata !== 16'h0040) begin
          failures++;
          $display("FAIL priority_irdata: got %h want 0040", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] grants;
    logic [2:0] exp_grants;
    int n_grants;
    int ack_cycle[3];
    apply_reset();
    mem_rd  = 16'h0000;
    i_addr  = 16'h0044;
    d_addr  = 16'h0088;
    d_wdata = 16'h5555;
    d_wr    = 1'b1;
    i_req   = 1'b1;
    d_req   = 1'b1;
    grants = 3'b000;
    n_grants = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_grants = 3'b101;
`else
    exp_grants = 3'b111;
`endif
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (i_ack && d_ack) begin
        failures++;
        $display("FAIL ack_overlap cycle %0d: got both acks high", k);
      end
      if (mem_enable) begin
        checks++;
        if (mem_wr !== (mem_addr == 16'h0088)) begin
          failures++;
          $display("FAIL tie_mem_wr cycle %0d: got wr=%b addr=%h", k, mem_wr, mem_addr);
        end
      end
      if ((i_ack || d_ack) && n_grants < 3) begin
        grants[2 - n_grants] = d_ack;
        ack_cycle[n_grants] = k;
        n_grants++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr  = 1'b0;
    checks++;
    if (n_grants != 3 || grants !== exp_grants) begin
      failures++;
      $display("FAIL tie_sequence: got %0d grants pattern %b (1=data) want 3 grants %b", n_grants, grants, exp_grants);
    end
    checks++;
    if (n_grants == 3 && (ack_cycle[0] != 5 || ack_cycle[1] != 11 || ack_cycle[2] != 17)) begin
      failures++;
      $display("FAIL tie_ack_cycles: got %0d,%0d,%0d want 5,11,17", ack_cycle[0], ack_cycle[1], ack_cycle[2]);
    end
    checks++;
    if (d_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL tie_store_rdata: got %h want 0000", d_rdata);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    mem_rd = 16'h0000;
    i_addr = 16'h0010;
    i_req  = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if (mem_enable !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got en=%b busy=%b want 1/1", mem_enable, busy);
    end
    rst   = 1'b1;
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      checks++;
      if ({i_ack, i_rdata, d_ack, d_rdata, mem_enable, mem_wr, mem_addr, mem_data_in, busy, dbg_state} !== '0) begin
        failures++;
        $display("FAIL abort_outputs cycle %0d: got ack=%b/%b en=%b busy=%b rd=%h, want all 0",
                 k, i_ack, d_ack, mem_enable, busy, i_rdata);
      end
      tick();
    end
  endtask

  task automatic test_lat1();
    logic [3:0] exp_ctl;
    apply_reset();
    l1_mem_rd = 16'h0F0F;
    l1_i_addr = 16'h0123;
    l1_i_req  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      // {mem_enable, i_ack, d_ack, busy}
      exp_ctl = {1'(k % 3 == 1), 1'(k % 3 == 2), 1'b0, 1'(k % 3 != 0)};
      checks++;
      if ({l1_mem_enable, l1_i_ack, l1_d_ack, l1_busy} !== exp_ctl) begin
        failures++;
        $display("FAIL lat1_ctl cycle %0d: got %b want %b", k, {l1_mem_enable, l1_i_ack, l1_d_ack, l1_busy}, exp_ctl);
      end
      if (k % 3 == 2) begin
        checks++;
        if (l1_i_rdata !== 16'h0E2C) begin
          failures++;
          $display("FAIL lat1_rdata cycle %0d: got %h want 0e2c", k, l1_i_rdata);
        end
      end
    end
    l1_i_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
